fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
// - Instruction fetch stage plus IF/ID pipeline register; direct upstream feeder of the control unit.
// - Holds the PC and drives the instruction-memory address.
// - Registers {inst, pc, pc+4, valid} for decode; applies hazard stalls and EX-stage redirects.
// - Stops fetching after ECALL/EBREAK; only a redirect or reset resumes fetch.
// PARAMETERS
// - RESET_PC  32'h0000_0000  PC value loaded on reset (low 2 bits must be 0)
// - NOP_INST  32'h0000_0013  bubble encoding (addi x0,x0,0) written into IF/ID
// PORTS
// - clk             in   1   single clock; all state on rising edge
// - rst             in   1   synchronous, active-high reset
// - stall           in   1   hazard unit: hold PC and IF/ID this cycle
// - redirect_valid  in   1   EX stage: taken branch/jal/jalr, load redirect_pc
// - redirect_pc     in   32  redirect target; bits [1:0] forced to 0
// - imem_addr       out  32  instruction address; combinational = pc
// - imem_rdata      in   32  instruction word, combinational read of imem_addr
// - if_id_inst      out  32  registered instruction to decode/control unit
// - if_id_pc        out  32  registered PC of if_id_inst
// - if_id_pc4       out  32  registered if_id_pc + 4 (link value for jal/jalr)
// - if_id_valid     out  1   1 = real instruction, 0 = bubble
// - halted          out  1   1 while in HALT state
// BEHAVIOUR
// - State machine: RUN, HALT.
// - Reset values: state RUN, pc RESET_PC, if_id_inst NOP_INST, if_id_pc 0, if_id_pc4 0,
//   if_id_valid 0, halted 0.
// - Priority per cycle: rst > redirect_valid > stall > normal fetch.
// - Redirect (any state, stall ignored):
//   - pc <= {redirect_pc[31:2],2'b00}.
//   - IF/ID <= bubble (NOP_INST, valid 0, pc/pc4 0).
//   - state <= RUN.
// - Stall (no redirect): pc, IF/ID and state all hold.
// - RUN, normal:
//   - IF/ID <= {imem_rdata, pc, pc+4, 1}.
//   - pc <= pc+4, modulo 2^32 (32'hFFFF_FFFC -> 0).
// - Halt detection (RUN, no stall, no redirect): imem_rdata[6:0]==7'b1110011 and [14:12]==3'b000
//   - Instruction is still latched into IF/ID with valid 1.
//   - pc holds at the ECALL/EBREAK address; state <= HALT.
//   - halted is 1 from the next cycle on.
// - HALT, no stall: IF/ID <= bubble each cycle; pc holds.
// - HALT, stall: IF/ID holds, so ECALL/EBREAK stays in ID until decode releases it.
// - Redirect in the same cycle as a fetched ECALL/EBREAK: redirect wins; no HALT entry.
// - FENCE, FENCE.TSO and PAUSE (opcode 0001111) are fetched as normal instructions: pc+4, no halt.
// - Latency: imem_rdata at pc appears on if_id_inst one clock later; redirect-to-fetch takes 1 clock.
// - rst asserted mid-operation (any state, stall or redirect): full reset values next edge.
// CONFIGURATION
// - FETCH_PERF_CNT_EN defined:
//   - Adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0]; both reset to 0, wrap at 2^32.
//   - fetch_cnt +1 on each cycle IF/ID loads valid=1.
//   - stall_cnt +1 on each cycle with stall=1 and redirect_valid=0.
// - FETCH_PERF_CNT_EN undefined: both ports and their counters are absent.
// TESTING
// - rst=1 for 2 clks -> imem_addr 0, if_id_valid 0, if_id_inst 32'h13, halted 0;
//   after release imem_rdata=32'h00500093 -> next clk if_id_pc 0, if_id_pc4 4, imem_addr 4.
// - 3 clks free-running -> if_id_pc 0,4,8, valid 1 each; imem_addr 4,8,12.
// - stall=1 for 2 clks at pc 8 -> imem_addr stays 8, if_id_pc stays 4;
//   stall=0 -> if_id_pc 8.
// - stall=1 with redirect_valid=1, redirect_pc 32'h103 -> imem_addr 32'h100, if_id_valid 0,
//   if_id_inst 32'h13; then redirect 32'hFFFF_FFFC, 1 free clk -> imem_addr 0.
// - imem_rdata 32'h00100073 at pc 32'h20 -> if_id_inst 32'h00100073 valid 1, imem_addr stays 32'h20,
//   halted 1, next clk if_id_valid 0; redirect 32'h40 -> halted 0, imem_addr 32'h40.
// - FETCH_PERF_CNT_EN: 5 fetches + 2 stall clks -> perf_fetch_cnt 5, perf_stall_cnt 2;
//   rst -> both 0.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register, stall/redirect handling and halt on ECALL/EBREAK
// Optional perf counters (perf_fetch_cnt, perf_stall_cnt) enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        is_halt_inst;
    logic        unused_redirect_low;

    assign imem_addr           = pc;
    assign pc_plus4            = pc + 32'd4;
    assign unused_redirect_low = ^redirect_pc[1:0];

    // ECALL/EBREAK share the SYSTEM opcode with funct3 = 000
    assign is_halt_inst = (imem_rdata[6:0] == 7'b1110011) && (imem_rdata[14:12] == 3'b000);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            if_id_inst  <= NOP_INST;
            if_id_pc    <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            halted      <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
`endif
        end else if (redirect_valid) begin
            state       <= RUN;
            pc          <= {redirect_pc[31:2], 2'b00};
            if_id_inst  <= NOP_INST;
            if_id_pc    <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (stall) begin
`ifdef FETCH_PERF_CNT_EN
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
`endif
        end else begin
            case (state)
                RUN: begin
                    if_id_inst  <= imem_rdata;
                    if_id_pc    <= pc;
                    if_id_pc4   <= pc_plus4;
                    if_id_valid <= 1'b1;
`ifdef FETCH_PERF_CNT_EN
                    perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
`endif
                    // pc stays on the ECALL/EBREAK so a later resume sees its address
                    if (is_halt_inst) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        pc <= pc_plus4;
                    end
                end
                HALT: begin
                    if_id_inst  <= NOP_INST;
                    if_id_pc    <= 32'd0;
                    if_id_pc4   <= 32'd0;
                    if_id_valid <= 1'b0;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - vector table and scoreboard bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid;
    logic [31:0] redirect_pc, imem_rdata;
    logic [31:0] imem_addr, if_id_inst, if_id_pc, if_id_pc4;
    logic        if_id_valid, halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_id_inst     (if_id_inst),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .if_id_valid    (if_id_valid),
        .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    typedef struct {
        logic        rst, stall, rv;
        logic [31:0] rpc, rdata;
        logic [31:0] addr, inst, pc, pc4;
        logic        valid, halted;
    } vec_t;

    typedef struct {
        logic [31:0] addr, inst, pc, pc4;
        logic        valid, halted;
        int          idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic r, input logic s, input logic rv,
                                input logic [31:0] rpc, input logic [31:0] rdata,
                                input logic [31:0] addr, input logic [31:0] inst,
                                input logic [31:0] pc, input logic [31:0] pc4,
                                input logic valid, input logic h);
        vec_t t;
        t.rst = r; t.stall = s; t.rv = rv; t.rpc = rpc; t.rdata = rdata;
        t.addr = addr; t.inst = inst; t.pc = pc; t.pc4 = pc4; t.valid = valid; t.halted = h;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic apply(input vec_t t, input int idx);
        exp_t e;
        @(negedge clk);
        rst = t.rst; stall = t.stall; redirect_valid = t.rv;
        redirect_pc = t.rpc; imem_rdata = t.rdata;
        e.addr = t.addr; e.inst = t.inst; e.pc = t.pc; e.pc4 = t.pc4;
        e.valid = t.valid; e.halted = t.halted; e.idx = idx;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty vec %0d: got 0 entries expected 1", idx);
        end else begin
            e = sb.pop_front();
            chk("imem_addr",   e.idx, imem_addr,          e.addr);
            chk("if_id_inst",  e.idx, if_id_inst,         e.inst);
            chk("if_id_pc",    e.idx, if_id_pc,           e.pc);
            chk("if_id_pc4",   e.idx, if_id_pc4,          e.pc4);
            chk("if_id_valid", e.idx, {31'd0, if_id_valid}, {31'd0, e.valid});
            chk("halted",      e.idx, {31'd0, halted},      {31'd0, e.halted});
        end
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'd0; imem_rdata = NOP;

        //            rst   stall rv    rpc           rdata         addr          inst          pc            pc4           v     h
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,        NOP,          32'h0,        NOP,          32'h0,        32'h0,        1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,        NOP,          32'h0,        NOP,          32'h0,        32'h0,        1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h00500093, 32'h4,        32'h00500093, 32'h0,        32'h4,        1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h00a00113, 32'h8,        32'h00a00113, 32'h4,        32'h8,        1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        32'h00208193, 32'h8,        32'h00a00113, 32'h4,        32'h8,        1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        32'h00208193, 32'h8,        32'h00a00113, 32'h4,        32'h8,        1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h00208193, 32'hc,        32'h00208193, 32'h8,        32'hc,        1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 32'h103,      32'h00000093, 32'h100,      NOP,          32'h0,        32'h0,        1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h0000000f, 32'h104,      32'h0000000f, 32'h100,      32'h104,      1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h0100000f, 32'h108,      32'h0100000f, 32'h104,      32'h108,      1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'hfffffffc, 32'h00000013, 32'hfffffffc, NOP,          32'h0,        32'h0,        1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h00000093, 32'h0,        32'h00000093, 32'hfffffffc, 32'h0,        1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h20,       32'h00000013, 32'h20,       NOP,          32'h0,        32'h0,        1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h00100073, 32'h20,       32'h00100073, 32'h20,       32'h24,       1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h00100073, 32'h20,       NOP,          32'h0,        32'h0,        1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h40,       32'h00100073, 32'h40,       NOP,          32'h0,        32'h0,        1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h00000073, 32'h40,       32'h00000073, 32'h40,       32'h44,       1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        32'h00000073, 32'h40,       32'h00000073, 32'h40,       32'h44,       1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h00000073, 32'h40,       NOP,          32'h0,        32'h0,        1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h80,       32'h00000073, 32'h0,        NOP,          32'h0,        32'h0,        1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h80,       32'h00000073, 32'h80,       NOP,          32'h0,        32'h0,        1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h00500093, 32'h84,       32'h00500093, 32'h80,       32'h84,       1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h00001073, 32'h88,       32'h00001073, 32'h84,       32'h88,       1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        32'h00000073, 32'h88,       32'h00001073, 32'h84,       32'h88,       1'b1, 1'b0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

`ifdef FETCH_PERF_CNT_EN
        // counters: reset, 5 fetches and 2 stalls, reset again
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; imem_rdata = NOP;
        repeat (2) @(posedge clk);
        #1;
        chk("perf_fetch_cnt_rst", 100, perf_fetch_cnt, 32'd0);
        chk("perf_stall_cnt_rst", 100, perf_stall_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        stall = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("perf_fetch_cnt", 101, perf_fetch_cnt, 32'd5);
        chk("perf_stall_cnt", 101, perf_stall_cnt, 32'd2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("perf_fetch_cnt_rst2", 102, perf_fetch_cnt, 32'd0);
        chk("perf_stall_cnt_rst2", 102, perf_stall_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
